// File: rtl/fractal_axis_packer.sv
// Packs the colorizer's RGB pixel stream into an AXI4-Stream video master (tuser=SOF, tlast=EOL).
// A DEPTH-entry FIFO absorbs tready backpressure; on overflow the rest of the frame is dropped until the next SOF.
module fractal_axis_packer #(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [23:0] data_in,
  input  logic        frame_start_in,
  input  logic        line_end_in,
  input  logic        data_enable_in,
  output logic        almost_full,
  output logic        overflow,
  input  logic        clear_overflow,
  output logic [15:0] drop_count,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_THR = CW'(DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    STREAM   = 2'd1,
    DROP     = 2'd2
  } state_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [23:0] rgb;
  } entry_t;

  state_t          r_state;
  state_t          w_state_nxt;
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_almost_full;
  logic            r_overflow;
  logic [15:0]     r_drop_count;
  logic            w_full;
  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_lost;
  logic            w_drop_inc;
  logic            w_valid;
  entry_t          w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_valid = (r_count != '0);
  assign w_rd_en = w_valid && m_axis_tready;

  // NOTE: every output of this block gets a default first so no path leaves a signal unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_lost      = 1'b0;
    w_drop_inc  = 1'b0;
    if (data_enable_in) begin
      unique case (r_state)
        STREAM: begin
          if (w_full) begin
            w_lost      = 1'b1;
            w_drop_inc  = 1'b1;
            w_state_nxt = DROP;
          end else begin
            w_wr_en = 1'b1;
          end
        end
        default: begin
          // WAIT_SOF and DROP both resync only on a SOF beat that fits in the FIFO.
          if (frame_start_in) begin
            if (w_full) begin
              w_lost = 1'b1;
            end else begin
              w_wr_en     = 1'b1;
              w_state_nxt = STREAM;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_en, w_rd_en})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= WAIT_SOF;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_almost_full <= (w_count_nxt >= AFULL_THR);
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_lost) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
      if (w_drop_inc && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // NOTE: storage has no reset; the count/pointers define validity, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= '{sof: frame_start_in, eol: line_end_in, rgb: data_in};
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign m_axis_tvalid = w_valid;
  assign m_axis_tdata  = w_valid ? w_head.rgb : 24'd0;
  assign m_axis_tuser  = w_valid & w_head.sof;
  assign m_axis_tlast  = w_valid & w_head.eol;
  assign almost_full   = r_almost_full;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_fractal_axis_packer.sv
// Self-checking bench for fractal_axis_packer: a negedge scoreboard model of the FIFO/frame FSM
// plus table-driven and hand-written sequences for framing, overflow and reset corner cases.
module tb_fractal_axis_packer;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic        clk = 1'b0;
  logic        resetn;
  logic [23:0] data_in;
  logic        frame_start_in;
  logic        line_end_in;
  logic        data_enable_in;
  logic        almost_full;
  logic        overflow;
  logic        clear_overflow;
  logic [15:0] drop_count;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  fractal_axis_packer #(.DEPTH(DEPTH), .AFULL_MARGIN(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_in        (data_in),
    .frame_start_in (frame_start_in),
    .line_end_in    (line_end_in),
    .data_enable_in (data_enable_in),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef logic [25:0] ent_t;  // {sof, eol, rgb}
  typedef enum int {M_WAIT, M_STREAM, M_DROP} mstate_t;

  ent_t        exp_q[$];
  ent_t        log_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  mstate_t     m_state = M_WAIT;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_drop  = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: at each negedge compare DUT state with the model, then advance the model for the coming edge.
  always @(negedge clk) begin : p_model
    int   sz;
    logic full, wr, lost, inc;
    if (!resetn) begin
      exp_q.delete();
      m_state = M_WAIT;
      m_ovf   = 1'b0;
      m_drop  = 16'd0;
    end else begin
      sz = exp_q.size();
      check("tvalid", m_axis_tvalid, sz != 0);
      check("almost_full", almost_full, sz >= AFULL);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drop);
      if (sz != 0) begin
        check("head_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q[0]);
        if (m_axis_tready) begin
          log_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
          void'(exp_q.pop_front());
        end
      end
      full = (sz == DEPTH);
      wr = 1'b0; lost = 1'b0; inc = 1'b0;
      if (data_enable_in) begin
        if (m_state == M_STREAM) begin
          if (full) begin lost = 1'b1; inc = 1'b1; m_state = M_DROP; end
          else wr = 1'b1;
        end else if (frame_start_in) begin
          if (full) lost = 1'b1;
          else begin wr = 1'b1; m_state = M_STREAM; end
        end
      end
      if (wr) exp_q.push_back({frame_start_in, line_end_in, data_in});
      if (lost) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      if (inc && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
  end

  task automatic drive(input logic de, input logic sof, input logic eol, input logic [23:0] d);
    data_enable_in = de;
    frame_start_in = sof;
    line_end_in    = eol;
    data_in        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    data_enable_in = 1'b0;
    m_axis_tready  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!m_axis_tvalid) break;
      drive(1'b0, 1'b0, 1'b0, 24'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 24'd0);
    check(name, m_axis_tvalid, 1'b0);
  endtask

  typedef struct {
    logic        de;
    logic        sof;
    logic        eol;
    logic [23:0] data;
    logic        emit;
  } vec_t;

  vec_t vecs[10];

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int k;
    // Pre-SOF beats (never emitted), a qualified-off SOF, then a 4-beat frame.
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 1'b0, (i == 2), 24'hA00000 + 24'(i), 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 24'hBADBAD, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 24'h112233, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 24'h445566, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 24'h778899, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 24'hAABBCC, 1'b1};

    resetn = 1'b0; data_in = '0; frame_start_in = 0; line_end_in = 0; data_enable_in = 0;
    clear_overflow = 0; m_axis_tready = 1'b1;
    #12;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_afull", almost_full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_count", drop_count, 16'd0);
    @(posedge clk); #2 resetn = 1'b1;
    @(posedge clk); #1;

    // Tests 1/2: table-driven framing.
    log_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].de, vecs[i].sof, vecs[i].eol, vecs[i].data);
      if (i == 5) begin
        check("pre_sof_nothing", log_q.size(), 0);
        check("pre_sof_tvalid", m_axis_tvalid, 1'b0);
        check("pre_sof_overflow", overflow, 1'b0);
      end
      if (i == 6) check("sof_latency_tvalid", m_axis_tvalid, 1'b1);
    end
    drain("t1_drain");
    check("t1_count", log_q.size(), 4);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].emit && k < log_q.size()) begin
        check("t1_beat", log_q[k], {vecs[i].sof, vecs[i].eol, vecs[i].data});
        k++;
      end
    end

    // Test 3: 20 beats into a stalled sink.
    log_q.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i == 0), 1'b0, 24'h300000 + 24'(i));
      check("t3_afull", almost_full, ((i + 1 > DEPTH) ? DEPTH : i + 1) >= AFULL);
    end
    drive(1'b0, 1'b0, 1'b0, 24'd0);
    check("t3_overflow", overflow, 1'b1);
    check("t3_drop_count", drop_count, 16'd1);
    drive(1'b1, 1'b0, 1'b1, 24'h3FFFFF);  // DROP state: discarded
    drain("t3_drain");
    check("t3_count", log_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < log_q.size(); i++)
      check("t3_beat", log_q[i], {(i == 0), 1'b0, 24'h300000 + 24'(i)});
    log_q.delete();
    drive(1'b1, 1'b1, 1'b0, 24'h350000);
    drive(1'b1, 1'b0, 1'b0, 24'h350001);
    drive(1'b1, 1'b0, 1'b1, 24'h350002);
    drain("t3_resume_drain");
    check("t3_resume_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t3_resume_first", log_q[0], {1'b1, 1'b0, 24'h350000});
      check("t3_resume_last", log_q[2], {1'b0, 1'b1, 24'h350002});
    end

    // Test 4: tready toggling, one beat every two cycles.
    clear_overflow = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'd0);
    clear_overflow = 1'b0;
    check("t4_cleared", overflow, 1'b0);
    log_q.delete();
    for (int i = 0; i < 40; i++) begin
      m_axis_tready = i[0];
      drive(!i[0], (i == 0), (i % 8 == 6), 24'h400000 + 24'(i));
    end
    drain("t4_drain");
    check("t4_no_overflow", overflow, 1'b0);
    check("t4_count", log_q.size(), 20);
    for (int i = 0; i < 20 && i < log_q.size(); i++)
      check("t4_beat", log_q[i], {(i == 0), ((2 * i) % 8 == 6), 24'h400000 + 24'(2 * i)});

    // Test 5: full FIFO with same-cycle pop and write, plus clear_overflow in that cycle.
    log_q.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, (i == 0), 1'b0, 24'h500000 + 24'(i));
    check("t5_full_afull", almost_full, 1'b1);
    check("t5_pre_overflow", overflow, 1'b0);
    m_axis_tready  = 1'b1;
    clear_overflow = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 24'h5000FF);
    clear_overflow = 1'b0;
    check("t5_set_beats_clear", overflow, 1'b1);
    check("t5_drop_count", drop_count, 16'd2);
    clear_overflow = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'd0);
    clear_overflow = 1'b0;
    check("t5_clear_alone", overflow, 1'b0);
    drain("t5_drain");
    check("t5_count", log_q.size(), DEPTH);
    if (log_q.size() == DEPTH) check("t5_last_kept", log_q[DEPTH-1], {1'b0, 1'b0, 24'h50000F});

    // Test 6: reset asserted mid-frame with 7 entries queued.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) drive(1'b1, (i == 0), 1'b0, 24'h600000 + 24'(i));
    data_enable_in = 1'b0;
    check("t6_pre_tvalid", m_axis_tvalid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_tvalid", m_axis_tvalid, 1'b0);
    check("t6_async_afull", almost_full, 1'b0);
    check("t6_async_drop", drop_count, 16'd0);
    check("t6_async_overflow", overflow, 1'b0);
    @(posedge clk); #2 resetn = 1'b1;
    @(posedge clk); #1;
    log_q.delete();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 24'h610000 + 24'(i));
    drive(1'b0, 1'b0, 1'b0, 24'd0);
    check("t6_wait_sof", log_q.size(), 0);
    drive(1'b1, 1'b1, 1'b0, 24'h620000);
    drive(1'b1, 1'b0, 1'b1, 24'h620001);
    drain("t6_drain");
    check("t6_count", log_q.size(), 2);
    if (log_q.size() == 2) check("t6_first", log_q[0], {1'b1, 1'b0, 24'h620000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
